// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC and instruction register front end of the multicycle datapath.
// Build option MISALIGN_TRAP_EN: a misaligned jump target is trapped (sticky misalign) instead of truncated.
//
//  state | meaning
//  IDLE  | single settling cycle after reset release
//  FETCH | imem_req high at pc, waiting for imem_ack with weIR
//  HOLD  | IR holds the instruction at pc, waiting for wePc
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              weIR,
    input  logic              wePc,
    input  logic              pc_sel,
    input  logic [ADDR_W-1:0] pc_target,
    output logic [6:0]        Opcode,
    output logic [4:0]        rd,
    output logic [2:0]        funct3,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              instr_valid,
    output logic              misalign
);

    localparam logic [31:0]       NOP_INSTR  = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [ADDR_W-1:0] jump_pc;
    logic              bad_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign jump_pc  = pc_target & ALIGN_MASK;
    assign pc_plus4 = pc_q + PC_INC;

`ifdef MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    assign bad_target = pc_sel & (pc_target[1:0] != 2'b00);

    always_comb begin
        misalign_d = misalign_q;
        if (state_q == HOLD && wePc && bad_target) begin
            misalign_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign = misalign_q;
`else
    assign bad_target = 1'b0;
    assign misalign   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                // an ack without weIR drops the word; the request simply stays up
                if (imem_ack && weIR) begin
                    ir_d    = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (wePc && !bad_target) begin
                    pc_d    = pc_sel ? jump_pc : pc_plus4;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == HOLD);
    assign pc          = pc_q;
    assign instr       = ir_q;
    assign Opcode      = ir_q[6:0];
    assign rd          = ir_q[11:7];
    assign funct3      = ir_q[14:12];
    assign rs1         = ir_q[19:15];
    assign rs2         = ir_q[24:20];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed literal checks plus randomized traffic
// compared every cycle against a transaction-level model of the fetch/hold protocol.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        weIR;
    logic        wePc;
    logic        pc_sel;
    logic [31:0] pc_target;
    logic [6:0]  Opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        misalign;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .weIR       (weIR),
        .wePc       (wePc),
        .pc_sel     (pc_sel),
        .pc_target  (pc_target),
        .Opcode     (Opcode),
        .rd         (rd),
        .funct3     (funct3),
        .rs1        (rs1),
        .rs2        (rs2),
        .instr      (instr),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .instr_valid(instr_valid),
        .misalign   (misalign)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: after reset, one dead cycle; then alternate between "waiting for a word at pc"
    // and "holding the word for pc" as the spec's handshake rules dictate.
    logic        m_started;
    logic        m_have_word;
    logic        m_mis;
    logic [31:0] m_pc;
    logic [31:0] m_ir;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started   = 1'b0;
            m_have_word = 1'b0;
            m_mis       = 1'b0;
            m_pc        = RST_PC;
            m_ir        = NOP;
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (!m_have_word) begin
            if (imem_ack && weIR) begin
                m_ir        = imem_rdata;
                m_have_word = 1'b1;
            end
        end else if (wePc) begin
`ifdef MISALIGN_TRAP_EN
            if (pc_sel && (pc_target % 4 != 0)) begin
                m_mis = 1'b1;
            end else begin
                m_pc        = pc_sel ? (pc_target / 4) * 4 : m_pc + 4;
                m_have_word = 1'b0;
            end
`else
            m_pc        = pc_sel ? (pc_target / 4) * 4 : m_pc + 4;
            m_have_word = 1'b0;
`endif
        end
    end

    always @(negedge clk) begin
        logic m_req;
        m_req = m_started && !m_have_word;
        chk("imem_req", imem_req, m_req);
        if (m_req) chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", instr_valid, m_have_word);
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("instr", instr, m_ir);
        chk("Opcode", Opcode, m_ir & 32'h7F);
        chk("rd", rd, (m_ir >> 7) & 32'h1F);
        chk("funct3", funct3, (m_ir >> 12) & 32'h7);
        chk("rs1", rs1, (m_ir >> 15) & 32'h1F);
        chk("rs2", rs2, (m_ir >> 20) & 32'h1F);
        chk("misalign", misalign, m_mis);
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        weIR       = 1'b0;
        wePc       = 1'b0;
        pc_sel     = 1'b0;
        pc_target  = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_pc", pc, 32'h100);
        chk("rst_opcode", Opcode, 7'b0010011);
        chk("rst_valid", instr_valid, 0);
        chk("rst_misalign", misalign, 0);
        #2 rst_n = 1'b1;

        cyc();
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 32'h100);
        imem_ack = 1'b1; weIR = 1'b1; imem_rdata = 32'h00A0_0093;
        cyc();
        imem_ack = 1'b0; weIR = 1'b0;
        chk("t1_valid", instr_valid, 1);
        chk("t1_opcode", Opcode, 7'b0010011);
        chk("t1_rd", rd, 5'd1);
        chk("t1_req_low", imem_req, 0);

        wePc = 1'b1; pc_sel = 1'b0;
        cyc();
        wePc = 1'b0;
        chk("t2_pc", pc, 32'h104);
        chk("t2_req", imem_req, 1);
        chk("t2_addr", imem_addr, 32'h104);

        imem_ack = 1'b1; weIR = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        cyc();
        chk("t4_ir_kept", instr, 32'h00A0_0093);
        chk("t4_req_kept", imem_req, 1);
        chk("t4_addr_kept", imem_addr, 32'h104);
        imem_ack = 1'b0;
        cyc();
        imem_ack = 1'b1; weIR = 1'b1; imem_rdata = 32'h00B0_0113;
        cyc();
        imem_ack = 1'b0; weIR = 1'b0;
        chk("t4_ir_load", instr, 32'h00B0_0113);
        chk("t4_valid", instr_valid, 1);

        wePc = 1'b1; pc_sel = 1'b1; pc_target = 32'h200;
        cyc();
        wePc = 1'b0;
        chk("t3_addr", imem_addr, 32'h200);
        imem_ack = 1'b1; weIR = 1'b1; imem_rdata = 32'h00C0_0193;
        cyc();
        imem_ack = 1'b0; weIR = 1'b0;
        chk("t3_plus4", pc_plus4, 32'h204);
        chk("t3_valid", instr_valid, 1);

        wePc = 1'b1; pc_sel = 1'b1; pc_target = 32'h202;
        cyc();
        wePc = 1'b0; pc_sel = 1'b0;
`ifdef MISALIGN_TRAP_EN
        chk("t6_pc_kept", pc, 32'h200);
        chk("t6_misalign", misalign, 1);
        chk("t6_valid", instr_valid, 1);
`else
        chk("t6_pc_trunc", pc, 32'h200);
        chk("t6_misalign", misalign, 0);
        chk("t6_req", imem_req, 1);
`endif

        wePc = 1'b1;
        cyc();
        wePc = 1'b0;
        imem_ack = 1'b1; weIR = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_req_drop", imem_req, 0);
        chk("t5_pc", pc, 32'h100);
        chk("t5_opcode", Opcode, 7'b0010011);
        chk("t5_valid", instr_valid, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        imem_ack = 1'b0; weIR = 1'b0;
        #1;
        chk("t5_ir_nop", instr, NOP);
        chk("t5_idle_req", imem_req, 0);
        @(negedge clk);

        for (int i = 0; i < 3000; i++) begin
            imem_ack   = ($urandom_range(0, 1) == 1);
            weIR       = ($urandom_range(0, 3) != 0);
            wePc       = ($urandom_range(0, 2) == 0);
            pc_sel     = ($urandom_range(0, 1) == 1);
            imem_rdata = $urandom;
            case ($urandom_range(0, 3))
                0:       pc_target = 32'hFFFF_FFFC;
                1:       pc_target = $urandom & 32'hFFFF_FFFC;
                2:       pc_target = $urandom;
                default: pc_target = 32'h200 | $urandom_range(0, 3);
            endcase
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                @(posedge clk);
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
